// File: rtl/seq_detector_prog_moore.sv
// Programmable serial pattern detector (1..MAX_LEN bits), overlap/non-overlap, saturating match count.
// Latency: last pattern bit sampled at edge N -> y and match_count valid after edge N.
// Backpressure: none; the stream is qualified by in_valid only and every valid bit is consumed.
module seq_detector_prog_moore #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               x,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN:0]   hist_x;
    logic [MAX_LEN-1:0] win;
    logic [MAX_LEN:0]   mask_ext;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic               fill_reach;
    logic               pat_eq;
    logic               sample;
    logic               match;
    logic               cfg_ok;
    logic [LEN_W-1:0]   fill_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    // Window includes the bit arriving this edge, so a match is flagged on the same edge it completes.
    always_comb begin
        hist_x     = {hist, x};
        win        = hist_x[MAX_LEN-1:0];
        mask_ext   = ((MAX_LEN+1)'(1) << len_r) - (MAX_LEN+1)'(1);
        mask       = mask_ext[MAX_LEN-1:0];
        fill_inc   = (LEN_W+1)'(fill) + (LEN_W+1)'(1);
        fill_reach = fill_inc >= (LEN_W+1)'(len_r);
        pat_eq     = ((win ^ pat_r) & mask) == '0;
        sample     = armed && in_valid && !cfg_load;
        match      = sample && fill_reach && pat_eq;
        cfg_ok     = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    end

    // Non-overlapping mode restarts the fill so the next match needs len_r fresh bits.
    always_comb begin
        fill_nxt = fill;
        if (match && !ovl_r) begin
            fill_nxt = '0;
        end else if (fill < len_r) begin
            fill_nxt = fill_inc[LEN_W-1:0];
        end
    end

    always_comb begin
        cnt_nxt = match_count;
        if (cnt_clr) begin
            cnt_nxt = match ? CNT_W'(1) : '0;
        end else if (match && match_count != CNT_MAX) begin
            cnt_nxt = match_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r <= '0;
            len_r <= '0;
            ovl_r <= 1'b0;
            hist  <= '0;
            fill  <= '0;
            armed <= 1'b0;
        end else if (cfg_load) begin
            pat_r <= cfg_pattern;
            len_r <= cfg_len;
            ovl_r <= cfg_overlap;
            hist  <= '0;
            fill  <= '0;
            armed <= cfg_ok;
        end else if (sample) begin
            hist  <= win;
            fill  <= fill_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y           <= 1'b0;
            match_count <= '0;
        end else begin
            y           <= match;
            match_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_seq_detector_prog_moore.sv
// Directed bench for seq_detector_prog_moore: reference model feeds a per-cycle scoreboard.
module tb_seq_detector_prog_moore;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       in_valid;
    logic       x;
    logic       cnt_clr;
    logic       y;
    logic [7:0] match_count;
    logic       armed;

    seq_detector_prog_moore #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .x           (x),
        .cnt_clr     (cnt_clr),
        .y           (y),
        .match_count (match_count),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    int ncomp = 0;
    int nfail = 0;

    // Reference model: full history of accepted bits plus count of bits since last restart.
    int         m_len;
    logic [7:0] m_pat;
    logic       m_ovl;
    logic       m_armed;
    int         m_fresh;
    int         m_cnt;
    logic       bits[$];

    logic       exp_y_q[$];
    int         exp_cnt_q[$];
    logic       exp_arm_q[$];

    task automatic chk(input string tag, input int obs, input int expv);
        ncomp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_len = 0; m_pat = '0; m_ovl = 1'b0; m_armed = 1'b0;
        m_fresh = 0; m_cnt = 0; bits.delete();
    endtask

    task automatic step(input logic v, input logic b, input logic ld, input logic clr, input string tag);
        logic hit;
        logic ey;
        int   ec;
        logic ea;
        hit = 1'b0;
        in_valid = v; x = b; cfg_load = ld; cnt_clr = clr;
        if (ld) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            m_armed = (m_len >= 1) && (m_len <= 8);
            m_fresh = 0; bits.delete();
        end else if (v && m_armed) begin
            bits.push_back(b);
            m_fresh++;
            if (m_fresh >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (bits[bits.size()-1-i] !== m_pat[i]) hit = 1'b0;
            end
            if (hit && !m_ovl) m_fresh = 0;
        end
        if (clr) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < 255) m_cnt++;
        exp_y_q.push_back(hit);
        exp_cnt_q.push_back(m_cnt);
        exp_arm_q.push_back(m_armed);
        @(posedge clk);
        #1;
        ey = exp_y_q.pop_front();
        ec = exp_cnt_q.pop_front();
        ea = exp_arm_q.pop_front();
        chk({tag, ".y"}, int'(y), int'(ey));
        chk({tag, ".count"}, int'(match_count), ec);
        chk({tag, ".armed"}, int'(armed), int'(ea));
        in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input string tag);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        step(1'b1, 1'b1, 1'b1, 1'b0, tag);
    endtask

    task automatic feed(input logic [7:0] s, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step(1'b1, s[i], 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        model_reset();
        chk("rst.y", int'(y), 0);
        chk("rst.count", int'(match_count), 0);
        chk("rst.armed", int'(armed), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; x = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #2;
        do_reset();

        // 1: overlapping 100
        load(8'b100, 4'd3, 1'b1, "t1.load");
        feed(8'b100100, 6, "t1.bit");
        chk("t1.final", int'(match_count), 2);

        // 2: 1010 overlap then non-overlap
        step(1'b0, 1'b0, 1'b0, 1'b1, "t2.clr");
        load(8'b1010, 4'd4, 1'b1, "t2a.load");
        feed(8'b10101010, 8, "t2a.bit");
        chk("t2a.final", int'(match_count), 3);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t2.clr2");
        load(8'b1010, 4'd4, 1'b0, "t2b.load");
        feed(8'b10101010, 8, "t2b.bit");
        chk("t2b.final", int'(match_count), 2);

        // 3: 110 with idle gaps between valid bits
        step(1'b0, 1'b0, 1'b0, 1'b1, "t3.clr");
        load(8'b110, 4'd3, 1'b1, "t3.load");
        step(1'b1, 1'b1, 1'b0, 1'b0, "t3.b1");
        step(1'b0, 1'b0, 1'b0, 1'b0, "t3.gap");
        step(1'b1, 1'b1, 1'b0, 1'b0, "t3.b2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "t3.gap");
        step(1'b1, 1'b0, 1'b0, 1'b0, "t3.b3");
        chk("t3.pulse", int'(y), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, "t3.after");
        chk("t3.final", int'(match_count), 1);

        // 4: len 1, continuous matches and counter saturation
        step(1'b0, 1'b0, 1'b0, 1'b1, "t4.clr");
        load(8'b1, 4'd1, 1'b1, "t4.load");
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "t4.bit");
        chk("t4.sat", int'(match_count), 255);
        step(1'b1, 1'b1, 1'b0, 1'b1, "t4.clr_match");
        chk("t4.clr_match", int'(match_count), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t4.clr_only");
        chk("t4.clr_only", int'(match_count), 0);

        // 5: full-length pattern, then invalid lengths disarm
        load(8'hA5, 4'd8, 1'b1, "t5.load");
        feed(8'hA5, 8, "t5.bit");
        chk("t5.final", int'(match_count), 1);
        load(8'h01, 4'd0, 1'b1, "t5.len0");
        chk("t5.len0.armed", int'(armed), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "t5.len0.bit");
        load(8'h01, 4'd9, 1'b1, "t5.len9");
        chk("t5.len9.armed", int'(armed), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "t5.len9.bit");
        chk("t5.disarmed_count", int'(match_count), 1);

        // 6: reset mid-pattern, then reload mid-pattern must not complete a match
        load(8'b100, 4'd3, 1'b1, "t6.load");
        feed(8'b10, 2, "t6.bit");
        do_reset();
        load(8'b100, 4'd3, 1'b1, "t6.reload");
        feed(8'b10, 2, "t6.pre");
        load(8'b100, 4'd3, 1'b1, "t6.midload");
        feed(8'b0, 1, "t6.post");
        chk("t6.nomatch", int'(match_count), 0);
        feed(8'b100, 3, "t6.fresh");
        chk("t6.final", int'(match_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
